// File: rtl/upbus_ramif_ctrl.sv
// upbus_ramif_ctrl
//   Host-side bridge: turns one-cycle host read/write strobes into the
//   held-level upen/upws/uprs access protocol of the RAM CPU-interface macro.
//   Optional watchdog (macro UPBUS_RAMIF_TOUT_EN) ends accesses that the macro
//   never completes and reports them through host_err.
//
// Handshakes:
//   Host side : a strobe (host_we/host_re) is accepted only in IDLE on a
//               window hit; host_busy high means strobes are ignored. Each
//               accepted strobe yields exactly one host_ack pulse (unless reset
//               intervenes), with host_err qualifying it and host_rdata valid.
//   Macro side: upen rises with a one-cycle upws/uprs and stays high, with upa
//               and updi stable, until uprdy is sampled (or the watchdog fires).
//               upen then stays low for at least two cycles (DONE, GAP).
module upbus_ramif_ctrl #(
  parameter int                      ADDRBIT  = 5,
  parameter int                      WIDTH    = 32,
  parameter int                      HADDRBIT = 16,
  parameter logic [HADDRBIT-1:0]     BASE     = 16'h0000,
  parameter int                      TOUT_CYC = 255,
  parameter logic [WIDTH-1:0]        ERRDATA  = 32'hDEAD_BEEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                host_we,
  input  logic                host_re,
  input  logic [HADDRBIT-1:0] host_addr,
  input  logic [WIDTH-1:0]    host_wdata,
  output logic [WIDTH-1:0]    host_rdata,
  output logic                host_ack,
  output logic                host_err,
  output logic                host_busy,
  output logic                upen,
  output logic [ADDRBIT-1:0]  upa,
  output logic                upws,
  output logic                uprs,
  output logic [WIDTH-1:0]    updi,
  input  logic [WIDTH-1:0]    updo,
  input  logic                uprdy,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_STRB = 3'd1,
    ST_WAIT = 3'd2,
    ST_DONE = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic                 is_wr_q;
  logic [ADDRBIT-1:0]   upa_q;
  logic [WIDTH-1:0]     updi_q;
  logic [WIDTH-1:0]     rdata_q;
  logic                 win_hit;
  logic                 accept;
  logic                 tout_hit;

  // Window decode on the address bits above the macro address field.
  assign win_hit = (host_addr[HADDRBIT-1:ADDRBIT] == BASE[HADDRBIT-1:ADDRBIT]);

  // A strobe is taken only in IDLE; strobes in any other state are dropped.
  assign accept  = (state_q == ST_IDLE) && win_hit && (host_we || host_re);

`ifdef UPBUS_RAMIF_TOUT_EN
  localparam logic [7:0] TOUT_LIM = 8'(TOUT_CYC);

  logic [7:0] wd_q;
  logic       err_q;

  assign tout_hit = (wd_q == TOUT_LIM);

  // Watchdog: cleared on the strobe cycle, counts every WAIT cycle that does
  // not end the access.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q <= 8'd0;
    end else if (state_q == ST_STRB) begin
      wd_q <= 8'd0;
    end else if ((state_q == ST_WAIT) && !uprdy && !tout_hit) begin
      wd_q <= wd_q + 8'd1;
    end
  end

  // Error flag: set by a watchdog exit, cleared by a normal completion.
  // uprdy on the limit cycle wins over the watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state_q == ST_WAIT) begin
      if (uprdy) begin
        err_q <= 1'b0;
      end else if (tout_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign host_err = err_q;
`else
  // Without the watchdog WAIT only ends on uprdy and no error is reported.
  logic unused_cfg;
  assign unused_cfg = ^{ERRDATA, TOUT_CYC};
  assign tout_hit   = 1'b0;
  assign host_err   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_STRB;
        end
      end
      ST_STRB: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (uprdy || tout_hit) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_GAP;
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request capture: address, write data and access type held for the access.
  // A simultaneous read strobe is dropped in favour of the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      upa_q   <= '0;
      updi_q  <= '0;
      is_wr_q <= 1'b0;
    end else if (accept) begin
      upa_q   <= host_addr[ADDRBIT-1:0];
      updi_q  <= host_wdata;
      is_wr_q <= host_we;
    end
  end

  // Read data: macro data on completion, ERRDATA on timeout, reads only.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if ((state_q == ST_WAIT) && !is_wr_q) begin
      if (uprdy) begin
        rdata_q <= updo;
      end
`ifdef UPBUS_RAMIF_TOUT_EN
      else if (tout_hit) begin
        rdata_q <= ERRDATA;
      end
`endif
    end
  end

  // Outputs decoded from the state register.
  always_comb begin
    upen      = 1'b0;
    upws      = 1'b0;
    uprs      = 1'b0;
    host_ack  = 1'b0;
    host_busy = 1'b0;
    case (state_q)
      ST_STRB: begin
        upen      = 1'b1;
        upws      = is_wr_q;
        uprs      = !is_wr_q;
        host_busy = 1'b1;
      end
      ST_WAIT: begin
        upen      = 1'b1;
        host_busy = 1'b1;
      end
      ST_DONE: begin
        host_ack  = 1'b1;
        host_busy = 1'b1;
      end
      default: begin
        upen      = 1'b0;
      end
    endcase
  end

  assign upa        = upa_q;
  assign updi       = updi_q;
  assign host_rdata = rdata_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_upbus_ramif_ctrl.sv
// tb_upbus_ramif_ctrl
//   Self-checking bench for upbus_ramif_ctrl. Define UPBUS_RAMIF_TOUT_EN on
//   the command line to also exercise the watchdog.
module tb_upbus_ramif_ctrl;

  localparam int              AB   = 5;
  localparam int              W    = 32;
  localparam int              HA   = 16;
  localparam logic [HA-1:0]   BASE = 16'h0100;
  localparam int              TOUT = 10;
  localparam logic [W-1:0]    ERRD = 32'hDEAD_BEEF;
  localparam int              NEVER = 1000;

  logic          clk = 1'b0;
  logic          rst;
  logic          host_we, host_re;
  logic [HA-1:0] host_addr;
  logic [W-1:0]  host_wdata, host_rdata;
  logic          host_ack, host_err, host_busy;
  logic          upen, upws, uprs, uprdy;
  logic [AB-1:0] upa;
  logic [W-1:0]  updi, updo;
  logic [2:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: last value host_rdata should hold.
  logic [W-1:0] model_rdata = '0;

  // Observations of one access.
  int s_at, a_at, wsc, rsc, hb, uh, ul, ea;
  logic e;
  logic [W-1:0] rd;

  upbus_ramif_ctrl #(
    .ADDRBIT(AB), .WIDTH(W), .HADDRBIT(HA), .BASE(BASE),
    .TOUT_CYC(TOUT), .ERRDATA(ERRD)
  ) dut (
    .clk(clk), .rst(rst),
    .host_we(host_we), .host_re(host_re), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack),
    .host_err(host_err), .host_busy(host_busy),
    .upen(upen), .upa(upa), .upws(upws), .uprs(uprs), .updi(updi),
    .updo(updo), .uprdy(uprdy), .dbg_state(dbg_state)
  );

  // Clock and global time limit.
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 2ms");
    $fatal(1, "global timeout");
  end

  // Ack position, counted in cycles from the upws/uprs cycle. WAIT spans the
  // cycles 1..TOUT+1 after the strobe cycle; uprdy in WAIT cycle L gives the
  // ack in cycle L+1, otherwise the watchdog acks in cycle TOUT+2.
  function automatic int exp_ack(int lat);
`ifdef UPBUS_RAMIF_TOUT_EN
    if (lat > TOUT + 1) return TOUT + 2;
`endif
    return lat + 1;
  endfunction

  function automatic bit exp_err(int lat);
`ifdef UPBUS_RAMIF_TOUT_EN
    return (lat > TOUT + 1);
`else
    return (lat < 0);
`endif
  endfunction

  // Driver + monitor for one host access. The macro is modelled as answering
  // uprdy 'lat' cycles after the upws/uprs cycle. inj>0 drives a second hit
  // strobe in cycle inj; inj<0 drives one in the cycle after the ack.
  task automatic run_access(input logic we, input logic re, input logic [HA-1:0] addr,
                            input logic [W-1:0] wdata, input int lat,
                            input logic [W-1:0] rv, input int inj, input int tail);
    int t;
    int k;
    bit done;
    s_at = -1; a_at = -1; wsc = 0; rsc = 0; hb = 0; uh = 0; ul = 0; ea = 0;
    e = 1'b0; rd = '0; k = 0; done = 0; t = 0;
    @(negedge clk);
    host_we = we; host_re = re; host_addr = addr; host_wdata = wdata; uprdy = 1'b0;
    while (!done && t < 80) begin
      @(negedge clk);
      t++;
      host_we = 1'b0; host_re = 1'b0; uprdy = 1'b0;
      if (upen) uh++;
      if (upws) wsc++;
      if (uprs) rsc++;
      if ((upws || uprs) && s_at < 0) s_at = t;
      if (upen && s_at >= 0 && a_at < 0 && (upa !== addr[AB-1:0] || updi !== wdata)) hb++;
      if (inj > 0 && t == inj) begin
        host_we = 1'b1;
        host_addr = {addr[HA-1:AB], ~addr[AB-1:0]};
        host_wdata = ~wdata;
      end
      if (s_at >= 0 && t == s_at + lat) begin
        uprdy = 1'b1;
        updo  = rv;
      end
      if (host_ack && a_at < 0) begin
        a_at = t - s_at;
        e    = host_err;
        rd   = host_rdata;
        if (!upen) ul++;
      end else if (a_at >= 0) begin
        k++;
        if (host_ack) ea++;
        if (k == 1 && !upen) ul++;
        if (k == 1 && inj < 0) begin
          host_re = 1'b1;
          host_addr = addr;
        end
        if (k >= tail) done = 1;
      end
    end
    host_we = 1'b0; host_re = 1'b0; uprdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; host_we = 1'b0; host_re = 1'b0; host_addr = '0; host_wdata = '0;
    uprdy = 1'b0; updo = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({host_rdata, host_ack, host_err, host_busy, upen, upa, upws, uprs, updi, dbg_state} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdata=%h ack=%b err=%b busy=%b upen=%b upa=%h upws=%b uprs=%b updi=%h st=%0d, required all zero",
               host_rdata, host_ack, host_err, host_busy, upen, upa, upws, uprs, updi, dbg_state);
    end
    rst = 1'b0;
    model_rdata = '0;
  endtask

  task automatic test_write();
    run_access(1'b1, 1'b0, BASE + 16'd3, 32'h1234_5678, 5, 32'h0, 0, 2);
    n_checks++;
    if (s_at !== 1) begin n_fail++; $display("FAIL wr_strobe_cycle: got %0d required 1", s_at); end
    n_checks++;
    if (wsc !== 1 || rsc !== 0) begin n_fail++; $display("FAIL wr_strobes: got upws=%0d uprs=%0d required 1/0", wsc, rsc); end
    n_checks++;
    if (hb !== 0) begin n_fail++; $display("FAIL wr_hold: got %0d unstable cycles required 0", hb); end
    n_checks++;
    if (a_at !== exp_ack(5)) begin n_fail++; $display("FAIL wr_ack_time: got %0d required %0d", a_at, exp_ack(5)); end
    n_checks++;
    if (e !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b required 0", e); end
    n_checks++;
    if (ul !== 2) begin n_fail++; $display("FAIL wr_upen_gap: got %0d low cycles required 2", ul); end
    n_checks++;
    if (uh !== exp_ack(5)) begin n_fail++; $display("FAIL wr_upen_len: got %0d required %0d", uh, exp_ack(5)); end
    n_checks++;
    if (rd !== model_rdata) begin n_fail++; $display("FAIL wr_rdata: got %h required %h", rd, model_rdata); end
  endtask

  task automatic test_read();
    run_access(1'b0, 1'b1, BASE + 16'd7, 32'h0, 3, 32'hA5A5_0F0F, 0, 2);
    model_rdata = 32'hA5A5_0F0F;
    n_checks++;
    if (rsc !== 1 || wsc !== 0) begin n_fail++; $display("FAIL rd_strobes: got upws=%0d uprs=%0d required 0/1", wsc, rsc); end
    n_checks++;
    if (a_at !== exp_ack(3)) begin n_fail++; $display("FAIL rd_ack_time: got %0d required %0d", a_at, exp_ack(3)); end
    n_checks++;
    if (rd !== model_rdata || e !== 1'b0) begin n_fail++; $display("FAIL rd_data: got %h err=%b required %h err=0", rd, e, model_rdata); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (host_rdata !== model_rdata) begin n_fail++; $display("FAIL rd_held: got %h required %h", host_rdata, model_rdata); end
    run_access(1'b1, 1'b0, BASE + 16'd9, 32'h0BAD_F00D, 2, 32'h1111_2222, 0, 2);
    n_checks++;
    if (rd !== model_rdata || host_rdata !== model_rdata) begin
      n_fail++; $display("FAIL rd_after_wr: got %h/%h required %h", rd, host_rdata, model_rdata);
    end
  endtask

  task automatic test_miss_busy();
    int acks;
    run_access(1'b0, 1'b1, BASE + 16'd32, 32'h0, 2, 32'h7777_7777, 0, 2);
    n_checks++;
    if (a_at !== -1 || uh !== 0 || s_at !== -1) begin
      n_fail++; $display("FAIL miss_ignored: got ack_at=%0d upen_cycles=%0d strobe_at=%0d required -1/0/-1", a_at, uh, s_at);
    end
    // Stray uprdy while idle must not produce an ack.
    acks = 0;
    @(negedge clk); uprdy = 1'b1;
    @(negedge clk); uprdy = 1'b0; if (host_ack) acks++;
    @(negedge clk); if (host_ack) acks++;
    n_checks++;
    if (acks !== 0) begin n_fail++; $display("FAIL stray_uprdy: got %0d acks required 0", acks); end
    // Second strobe during WAIT is dropped.
    run_access(1'b1, 1'b0, BASE + 16'd12, 32'hCAFE_0001, 6, 32'h0, 4, 12);
    n_checks++;
    if (ea !== 0 || hb !== 0 || uh !== exp_ack(6)) begin
      n_fail++; $display("FAIL busy_drop: got extra_acks=%0d unstable=%0d upen_cycles=%0d required 0/0/%0d", ea, hb, uh, exp_ack(6));
    end
    // Strobe during GAP is dropped.
    run_access(1'b1, 1'b0, BASE + 16'd1, 32'hCAFE_0002, 2, 32'h0, -1, 10);
    n_checks++;
    if (ea !== 0 || uh !== exp_ack(2) || wsc !== 1 || rsc !== 0) begin
      n_fail++; $display("FAIL gap_drop: got extra_acks=%0d upen_cycles=%0d upws=%0d uprs=%0d required 0/%0d/1/0", ea, uh, wsc, rsc, exp_ack(2));
    end
  endtask

  task automatic test_both();
    run_access(1'b1, 1'b1, BASE + 16'd20, 32'h5555_AAAA, 2, 32'h9999_9999, 0, 2);
    n_checks++;
    if (wsc !== 1 || rsc !== 0) begin n_fail++; $display("FAIL both_write_wins: got upws=%0d uprs=%0d required 1/0", wsc, rsc); end
    n_checks++;
    if (rd !== model_rdata) begin n_fail++; $display("FAIL both_rdata: got %h required %h", rd, model_rdata); end
  endtask

  task automatic test_timeout();
`ifdef UPBUS_RAMIF_TOUT_EN
    run_access(1'b0, 1'b1, BASE + 16'd5, 32'h0, NEVER, 32'h0, 0, 2);
    model_rdata = ERRD;
    n_checks++;
    if (a_at !== TOUT + 2 || e !== 1'b1 || rd !== ERRD) begin
      n_fail++; $display("FAIL tout_read: got ack_at=%0d err=%b rdata=%h required %0d/1/%h", a_at, e, rd, TOUT + 2, ERRD);
    end
    n_checks++;
    if (ul !== 2) begin n_fail++; $display("FAIL tout_upen_drop: got %0d low cycles required 2", ul); end
    run_access(1'b1, 1'b0, BASE + 16'd6, 32'h0000_00C3, 2, 32'h0, 0, 2);
    n_checks++;
    if (a_at !== 3 || e !== 1'b0 || rd !== model_rdata) begin
      n_fail++; $display("FAIL tout_recover: got ack_at=%0d err=%b rdata=%h required 3/0/%h", a_at, e, rd, model_rdata);
    end
    run_access(1'b0, 1'b1, BASE + 16'd8, 32'h0, TOUT + 1, 32'h0F0F_1234, 0, 2);
    model_rdata = 32'h0F0F_1234;
    n_checks++;
    if (a_at !== TOUT + 2 || e !== 1'b0 || rd !== model_rdata) begin
      n_fail++; $display("FAIL tout_boundary: got ack_at=%0d err=%b rdata=%h required %0d/0/%h", a_at, e, rd, TOUT + 2, model_rdata);
    end
    run_access(1'b1, 1'b0, BASE + 16'd2, 32'h0000_0042, NEVER, 32'h0, 0, 2);
    n_checks++;
    if (a_at !== TOUT + 2 || e !== 1'b1 || rd !== model_rdata) begin
      n_fail++; $display("FAIL tout_write: got ack_at=%0d err=%b rdata=%h required %0d/1/%h", a_at, e, rd, TOUT + 2, model_rdata);
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      int kind;
      int lat;
      logic we;
      logic re;
      logic [AB-1:0] off;
      logic [W-1:0] wd;
      logic [W-1:0] rv;
      kind = $urandom_range(0, 2);
      we = (kind != 0);
      re = (kind != 1);
`ifdef UPBUS_RAMIF_TOUT_EN
      lat = $urandom_range(1, 14);
`else
      lat = $urandom_range(1, 8);
`endif
      off = AB'($urandom);
      wd  = $urandom;
      rv  = $urandom;
      run_access(we, re, {BASE[HA-1:AB], off}, wd, lat, rv, 0, 2);
      if (!we) model_rdata = exp_err(lat) ? ERRD : rv;
      n_checks++;
      if (a_at !== exp_ack(lat) || e !== exp_err(lat) || rd !== model_rdata ||
          wsc !== int'(we) || rsc !== int'(!we) || hb !== 0) begin
        n_fail++;
        $display("FAIL random_%0d: got ack_at=%0d err=%b rdata=%h upws=%0d uprs=%0d unstable=%0d required %0d/%b/%h/%0d/%0d/0",
                 i, a_at, e, rd, wsc, rsc, hb, exp_ack(lat), exp_err(lat), model_rdata, int'(we), int'(!we));
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    host_re = 1'b1; host_addr = BASE + 16'd4; host_wdata = 32'h0;
    @(negedge clk); host_re = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (upen !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_wait: got upen=%b required 1", upen); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({host_rdata, host_ack, host_err, host_busy, upen, upa, upws, uprs, updi, dbg_state} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got rdata=%h ack=%b err=%b busy=%b upen=%b upa=%h st=%0d, required all zero",
               host_rdata, host_ack, host_err, host_busy, upen, upa, dbg_state);
    end
    rst = 1'b0;
    model_rdata = '0;
    uprdy = 1'b1;
    @(negedge clk); uprdy = 1'b0;
    @(negedge clk);
    n_checks++;
    if (host_ack !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_ack: got ack=%b required 0", host_ack); end
    run_access(1'b0, 1'b1, BASE + 16'd30, 32'h0, 4, 32'h3C3C_C3C3, 0, 2);
    model_rdata = 32'h3C3C_C3C3;
    n_checks++;
    if (a_at !== exp_ack(4) || rd !== model_rdata) begin
      n_fail++; $display("FAIL rstmid_recover: got ack_at=%0d rdata=%h required %0d/%h", a_at, rd, exp_ack(4), model_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_miss_busy();
    test_both();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
